// File: rtl/tensor_pkg.sv
// Shared tile constants, sequencer state type and matrix<->tile bit index helpers.
package tensor_pkg;
  localparam int TILE = 4;
  localparam int TILE_BITS = TILE * TILE;

  typedef enum logic [1:0] {IDLE, RUN, FIN} seq_state_e;

  // Bit position of element (r,c) inside a flattened 4x4 tile.
  function automatic int tile_bit_idx(input int r, input int c);
    return r * TILE + c;
  endfunction

  // Bit position in a flattened dim x dim matrix of element (r,c) of tile (p,q).
  function automatic int mat_bit_idx(input int dim, input int p, input int q,
                                     input int r, input int c);
    return (TILE * p + r) * dim + (TILE * q + c);
  endfunction
endpackage

// File: rtl/tensor.sv
// 4x4 boolean tile datapath: OUT = C | (A AND/OR B), purely combinational.
module tensor
  import tensor_pkg::*;
(
  input  logic [TILE_BITS-1:0] A_flat,
  input  logic [TILE_BITS-1:0] B_flat,
  input  logic [TILE_BITS-1:0] C_flat,
  output logic [TILE_BITS-1:0] OUT_flat
);
  always_comb begin
    OUT_flat = C_flat;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        for (int m = 0; m < TILE; m++) begin
          OUT_flat[tile_bit_idx(r, c)] = OUT_flat[tile_bit_idx(r, c)]
                                       | (A_flat[tile_bit_idx(r, m)] & B_flat[tile_bit_idx(m, c)]);
        end
      end
    end
  end
endmodule

// File: rtl/tensor_seq_ctrl.sv
// DIMxDIM boolean matmul sequencer, one tile-pass per clock (K^3 passes, done one cycle later);
// start is ignored unless idle. TENSOR_SEQ_ZSKIP_EN skips passes whose A tile is all-zero.
module tensor_seq_ctrl
  import tensor_pkg::*;
#(
  parameter int DIM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIM*DIM-1:0]   a_flat,
  input  logic [DIM*DIM-1:0]   b_flat,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [DIM*DIM-1:0]   out_flat,
  output logic [7:0]           pass_cnt
);
  localparam int K = DIM / TILE;
  localparam int CW = 2;
  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  seq_state_e         state_q, state_d;
  logic [DIM*DIM-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CW-1:0]      i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0]         pass_cnt_q, pass_cnt_d;
  logic               out_valid_q, out_valid_d;

  logic [CW-1:0]      sel_i, sel_j, sel_k, nxt_i, nxt_j, nxt_k;
  logic               pass_vld, last_pass;
  logic [TILE_BITS-1:0] a_tile, b_tile, c_tile, out_tile;

`ifdef TENSOR_SEQ_ZSKIP_EN
  logic [K*K-1:0] nz;

  always_comb begin
    nz = '0;
    for (int ii = 0; ii < K; ii++)
      for (int kk = 0; kk < K; kk++)
        for (int r = 0; r < TILE; r++)
          for (int c = 0; c < TILE; c++)
            nz[ii*K+kk] = nz[ii*K+kk] | a_q[mat_bit_idx(DIM, ii, kk, r, c)];
  end

  // Execute the first non-zero pass at or after the counters; finish when none follows it.
  always_comb begin
    logic found, more;
    int   cur;
    found = 1'b0;
    more  = 1'b0;
    cur   = (int'(i_q) * K + int'(j_q)) * K + int'(k_q);
    sel_i = i_q;
    sel_j = j_q;
    sel_k = k_q;
    nxt_i = '0;
    nxt_j = '0;
    nxt_k = '0;
    for (int n = 0; n < K*K*K; n++) begin
      if (n >= cur && nz[(n / (K*K)) * K + (n % K)]) begin
        if (!found) begin
          found = 1'b1;
          sel_i = CW'(n / (K*K));
          sel_j = CW'((n / K) % K);
          sel_k = CW'(n % K);
        end else if (!more) begin
          more  = 1'b1;
          nxt_i = CW'(n / (K*K));
          nxt_j = CW'((n / K) % K);
          nxt_k = CW'(n % K);
        end
      end
    end
    pass_vld  = found;
    last_pass = !more;
  end
`else
  always_comb begin
    sel_i     = i_q;
    sel_j     = j_q;
    sel_k     = k_q;
    pass_vld  = 1'b1;
    last_pass = (i_q == KM1) && (j_q == KM1) && (k_q == KM1);
    nxt_i     = i_q;
    nxt_j     = j_q;
    nxt_k     = k_q + ONE;
    if (k_q == KM1) begin
      nxt_k = '0;
      nxt_j = j_q + ONE;
      if (j_q == KM1) begin
        nxt_j = '0;
        nxt_i = i_q + ONE;
      end
    end
  end
`endif

  always_comb begin
    a_tile = '0;
    b_tile = '0;
    c_tile = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        a_tile[tile_bit_idx(r, c)] = a_q[mat_bit_idx(DIM, int'(sel_i), int'(sel_k), r, c)];
        b_tile[tile_bit_idx(r, c)] = b_q[mat_bit_idx(DIM, int'(sel_k), int'(sel_j), r, c)];
        c_tile[tile_bit_idx(r, c)] = r_q[mat_bit_idx(DIM, int'(sel_i), int'(sel_j), r, c)];
      end
    end
  end

  tensor u_tensor (
    .A_flat   (a_tile),
    .B_flat   (b_tile),
    .C_flat   (c_tile),
    .OUT_flat (out_tile)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    pass_cnt_d  = pass_cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          a_d         = a_flat;
          b_d         = b_flat;
          r_d         = '0;
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          pass_cnt_d  = '0;
          out_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (pass_vld) begin
          for (int r = 0; r < TILE; r++)
            for (int c = 0; c < TILE; c++)
              r_d[mat_bit_idx(DIM, int'(sel_i), int'(sel_j), r, c)] = out_tile[tile_bit_idx(r, c)];
          if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
        end
        if (last_pass) begin
          state_d     = FIN;
          out_valid_d = 1'b1;
        end else begin
          i_d = nxt_i;
          j_d = nxt_j;
          k_d = nxt_k;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      pass_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      pass_cnt_q  <= pass_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign out_valid = out_valid_q;
  assign out_flat  = r_q;
  assign pass_cnt  = pass_cnt_q;
endmodule

// File: tb/tb_tensor_seq_ctrl.sv
// Bench for tensor_seq_ctrl (DIM=8): vector table, hand-written handshake/reset sequences, random jobs.
module tb_tensor_seq_ctrl;
  localparam int DIM = 8;
  localparam int K = DIM / 4;
  localparam int N = DIM * DIM;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a_flat = '0;
  logic [N-1:0] b_flat = '0;
  logic         busy, done, out_valid;
  logic [N-1:0] out_flat;
  logic [7:0]   pass_cnt;

  int checks = 0;
  int failures = 0;

  tensor_seq_ctrl #(.DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_flat  (out_flat),
    .pass_cnt  (pass_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_m(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_mat();
    return {$urandom(), $urandom()};
  endfunction

  // Reference: plain boolean matrix product over full rows/columns.
  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] o = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        for (int m = 0; m < DIM; m++)
          if (a[r*DIM+m] && b[m*DIM+c]) o[r*DIM+c] = 1'b1;
    return o;
  endfunction

  function automatic int ref_passes(input logic [N-1:0] a);
`ifdef TENSOR_SEQ_ZSKIP_EN
    int cnt = 0;
    for (int p = 0; p < K; p++)
      for (int q = 0; q < K; q++) begin
        bit any = 1'b0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (a[(4*p+r)*DIM + 4*q + c]) any = 1'b1;
        if (any) cnt += K;
      end
    return cnt;
`else
    return K * K * K;
`endif
  endfunction

  task automatic run_job(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_o, input bit repulse);
    int cyc, exp_pc, exp_cyc, bad;
    exp_pc  = ref_passes(a);
    exp_cyc = ((exp_pc < 1) ? 1 : exp_pc) + 1;
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a_flat = rand_mat();
    b_flat = rand_mat();
    cyc = 0;
    bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk_m({name, " cleared_out"}, out_flat, '0);
        chk_i({name, " cleared_valid"}, int'(out_valid), 0);
      end
      if (!done && (!busy || out_valid)) bad++;
      start = repulse && (cyc == 2);
      if (start) begin
        a_flat = rand_mat();
        b_flat = rand_mat();
      end
    end while (!done && cyc < 300);
    chk_i({name, " done_cycle"}, cyc, exp_cyc);
    chk_i({name, " busy_window"}, bad, 0);
    chk_m({name, " out_flat"}, out_flat, exp_o);
    chk_i({name, " pass_cnt"}, int'(pass_cnt), (exp_pc > 255) ? 255 : exp_pc);
    chk_i({name, " busy_at_done"}, int'(busy), 0);
    chk_i({name, " valid_at_done"}, int'(out_valid), 1);
    start = repulse;
    a_flat = rand_mat();
    b_flat = rand_mat();
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      if (done || busy || !out_valid || out_flat !== exp_o) bad++;
    end
    chk_i({name, " hold_after_done"}, bad, 0);
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int bad;
    logic [N-1:0] ra, rb;

    tbl[0] = '{"identity", 64'h8040201008040201, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    tbl[1] = '{"all_ones", '1, '1, '1};
    tbl[2] = '{"cross_tile", 64'h0000000000000080, 64'h0100000000000000, 64'h0000000000000001};
    tbl[3] = '{"a_zero", '0, '1, '0};
    tbl[4] = '{"tile11_only", 64'hF0F0F0F000000000, '1, 64'hFFFFFFFF00000000};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_i("reset busy", int'(busy), 0);
    chk_i("reset done", int'(done), 0);
    chk_i("reset out_valid", int'(out_valid), 0);
    chk_m("reset out_flat", out_flat, '0);
    chk_i("reset pass_cnt", int'(pass_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_job(tbl[v].name, tbl[v].a, tbl[v].b, tbl[v].exp, 1'b0);

    // Re-pulsed start during RUN and on the done cycle must be ignored.
    ra = rand_mat();
    run_job("repulse", ra, 64'h8040201008040201, ra, 1'b1);
    run_job("after_repulse", '1, 64'h8040201008040201, '1, 1'b0);

    // Reset in the middle of a job.
    a_flat = '1;
    b_flat = '1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk_i("midjob pass_cnt_before_reset", int'(pass_cnt), 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_i("midjob busy", int'(busy), 0);
    chk_i("midjob done", int'(done), 0);
    chk_m("midjob out_flat", out_flat, '0);
    chk_i("midjob pass_cnt", int'(pass_cnt), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy || out_valid) bad++;
    end
    chk_i("midjob no_done", bad, 0);
    run_job("post_reset", 64'h8040201008040201, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0);

    for (int t = 0; t < 8; t++) begin
      ra = rand_mat() & rand_mat();
      for (int p = 0; p < K; p++)
        for (int q = 0; q < K; q++)
          if ($urandom_range(0, 2) == 0)
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                ra[(4*p+r)*DIM + 4*q + c] = 1'b0;
      rb = rand_mat();
      run_job($sformatf("random%0d", t), ra, rb, ref_mul(ra, rb), t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
